// File: rtl/parity_window_acc_if.sv
// Handshake/data bundle between the parity sample source, the window
// accumulator and the status consumer.
interface parity_window_acc_if #(
    parameter int CNT_W = 5
) ();
    logic             in_start;
    logic             in_valid;
    logic             in_sum;
    logic             in_ack;
    logic             out_busy;
    logic             out_valid;
    logic [CNT_W-1:0] out_count;
    logic             out_alarm;
    logic             out_overrun;
    logic [CNT_W-1:0] out_max_run;

    modport master (
        output in_start, in_valid, in_sum, in_ack,
        input  out_busy, out_valid, out_count, out_alarm, out_overrun, out_max_run
    );

    modport slave (
        input  in_start, in_valid, in_sum, in_ack,
        output out_busy, out_valid, out_count, out_alarm, out_overrun, out_max_run
    );
endinterface

// File: rtl/parity_window_acc.sv
// Counts asserted parity samples over a window of WIN_LEN accepted samples and
// holds the total/alarm behind a valid/ack handshake. Define PARITY_WIN_RUN_EN
// to compile in the longest-run-of-ones tracker.
module parity_window_acc #(
    parameter int WIN_LEN = 16,
    parameter int CNT_W   = 5,
    parameter int THRESH  = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    parity_window_acc_if.slave   bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACC  = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WIN_LEN - 1);
    localparam logic [CNT_W:0]   THRESH_W = (CNT_W + 1)'(THRESH);
    localparam logic [CNT_W-1:0] ZERO_CNT = {CNT_W{1'b0}};

    function automatic logic [CNT_W-1:0] add_bit(input logic [CNT_W-1:0] a, input logic b);
        return a + {{(CNT_W - 1){1'b0}}, b};
    endfunction

    state_t           state_q,   state_d;
    logic [CNT_W-1:0] smp_q,     smp_d;
    logic [CNT_W-1:0] ones_q,    ones_d;
    logic [CNT_W-1:0] count_q,   count_d;
    logic             busy_q,    busy_d;
    logic             valid_q,   valid_d;
    logic             alarm_q,   alarm_d;
    logic             overrun_q, overrun_d;

    logic             clr_s;
    logic             take_s;
    logic             done_s;
    logic [CNT_W-1:0] ones_inc_s;

`ifdef PARITY_WIN_RUN_EN
    logic [CNT_W-1:0] cur_run_q,    cur_run_d;
    logic [CNT_W-1:0] win_max_q,    win_max_d;
    logic [CNT_W-1:0] max_out_q,    max_out_d;
    logic [CNT_W-1:0] run_inc_s;
    logic [CNT_W-1:0] max_inc_s;
`endif

    // Candidate counter values assuming the current sample is accepted.
    always_comb begin
        ones_inc_s = add_bit(ones_q, bus.in_sum);
`ifdef PARITY_WIN_RUN_EN
        if (bus.in_sum) begin
            run_inc_s = add_bit(cur_run_q, 1'b1);
        end else begin
            run_inc_s = ZERO_CNT;
        end
        if (run_inc_s > win_max_q) begin
            max_inc_s = run_inc_s;
        end else begin
            max_inc_s = win_max_q;
        end
`endif
    end

    // Window sequencing: next state, clear/accept strobes and overrun flag.
    always_comb begin
        state_d   = state_q;
        overrun_d = overrun_q;
        clr_s     = 1'b0;
        take_s    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.in_start) begin
                    state_d   = ST_ACC;
                    clr_s     = 1'b1;
                    overrun_d = 1'b0;
                end else if (bus.in_valid) begin
                    overrun_d = 1'b1;
                end else begin
                    overrun_d = overrun_q;
                end
            end
            ST_ACC: begin
                // A restart wins over a same-cycle sample, which is dropped.
                if (bus.in_start) begin
                    clr_s     = 1'b1;
                    overrun_d = 1'b0;
                end else if (bus.in_valid) begin
                    take_s = 1'b1;
                    if (smp_q == LAST_IDX) begin
                        state_d = ST_HOLD;
                    end else begin
                        state_d = ST_ACC;
                    end
                end else begin
                    state_d = ST_ACC;
                end
            end
            ST_HOLD: begin
                if (bus.in_ack && bus.in_start) begin
                    state_d   = ST_ACC;
                    clr_s     = 1'b1;
                    overrun_d = 1'b0;
                end else begin
                    if (bus.in_ack) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_HOLD;
                    end
                    if (bus.in_valid) begin
                        overrun_d = 1'b1;
                    end else begin
                        overrun_d = overrun_q;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Window counters and the result registers loaded on the final sample.
    always_comb begin
        smp_d   = smp_q;
        ones_d  = ones_q;
        count_d = count_q;
        alarm_d = alarm_q;
        done_s  = take_s && (smp_q == LAST_IDX);
`ifdef PARITY_WIN_RUN_EN
        cur_run_d = cur_run_q;
        win_max_d = win_max_q;
        max_out_d = max_out_q;
`endif
        if (clr_s) begin
            smp_d  = ZERO_CNT;
            ones_d = ZERO_CNT;
`ifdef PARITY_WIN_RUN_EN
            cur_run_d = ZERO_CNT;
            win_max_d = ZERO_CNT;
`endif
        end else if (take_s) begin
            smp_d  = add_bit(smp_q, 1'b1);
            ones_d = ones_inc_s;
`ifdef PARITY_WIN_RUN_EN
            cur_run_d = run_inc_s;
            win_max_d = max_inc_s;
`endif
        end else begin
            smp_d  = smp_q;
            ones_d = ones_q;
        end

        if (done_s) begin
            count_d = ones_inc_s;
            alarm_d = ({1'b0, ones_inc_s} >= THRESH_W);
`ifdef PARITY_WIN_RUN_EN
            max_out_d = max_inc_s;
`endif
        end else if (state_d != ST_HOLD) begin
            alarm_d = 1'b0;
        end else begin
            alarm_d = alarm_q;
        end

        busy_d  = (state_d == ST_ACC);
        valid_d = (state_d == ST_HOLD);
    end

    // State and result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            smp_q     <= ZERO_CNT;
            ones_q    <= ZERO_CNT;
            count_q   <= ZERO_CNT;
            busy_q    <= 1'b0;
            valid_q   <= 1'b0;
            alarm_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            smp_q     <= smp_d;
            ones_q    <= ones_d;
            count_q   <= count_d;
            busy_q    <= busy_d;
            valid_q   <= valid_d;
            alarm_q   <= alarm_d;
            overrun_q <= overrun_d;
        end
    end

`ifdef PARITY_WIN_RUN_EN
    // Run tracker registers; runs never span windows.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_run_q <= ZERO_CNT;
            win_max_q <= ZERO_CNT;
            max_out_q <= ZERO_CNT;
        end else begin
            cur_run_q <= cur_run_d;
            win_max_q <= win_max_d;
            max_out_q <= max_out_d;
        end
    end

    assign bus.out_max_run = max_out_q;
`else
    assign bus.out_max_run = ZERO_CNT;
`endif

    assign bus.out_busy    = busy_q;
    assign bus.out_valid   = valid_q;
    assign bus.out_count   = count_q;
    assign bus.out_alarm   = alarm_q;
    assign bus.out_overrun = overrun_q;

endmodule

// File: tb/tb_parity_window_acc.sv
// Directed plus randomized bench for parity_window_acc, checked cycle by cycle
// against a queue-based window model.
module tb_parity_window_acc;
    localparam int WIN_LEN = 16;
    localparam int CNT_W   = 5;
    localparam int THRESH  = 8;
`ifdef PARITY_WIN_RUN_EN
    localparam int RUN_ON  = 1;
`else
    localparam int RUN_ON  = 0;
`endif

    logic clk;
    logic rst_n;

    parity_window_acc_if #(.CNT_W(CNT_W)) bus ();

    parity_window_acc #(.WIN_LEN(WIN_LEN), .CNT_W(CNT_W), .THRESH(THRESH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int total_cnt = 0;
    int pass_cnt  = 0;
    int fail_cnt  = 0;

    // Reference model: accepted samples of the open window plus expected outputs.
    bit win_q[$];
    bit m_busy, m_valid, m_alarm, m_overrun;
    int m_count, m_maxrun;

    function automatic int ones_of();
        int n = 0;
        foreach (win_q[i]) n += int'(win_q[i]);
        return n;
    endfunction

    function automatic int longest_run();
        int best = 0;
        int run  = 0;
        foreach (win_q[i]) begin
            run  = win_q[i] ? run + 1 : 0;
            best = (run > best) ? run : best;
        end
        return (RUN_ON != 0) ? best : 0;
    endfunction

    task automatic model_reset();
        win_q.delete();
        m_busy = 0; m_valid = 0; m_alarm = 0; m_overrun = 0;
        m_count = 0; m_maxrun = 0;
    endtask

    task automatic model_open();
        win_q.delete();
        m_busy    = 1;
        m_overrun = 0;
    endtask

    task automatic model_edge(input bit s, input bit v, input bit d, input bit a);
        if (m_busy) begin
            if (s) begin
                model_open();
            end else if (v) begin
                win_q.push_back(d);
                if (win_q.size() == WIN_LEN) begin
                    m_count  = ones_of();
                    m_alarm  = (m_count >= THRESH);
                    m_maxrun = longest_run();
                    m_busy   = 0;
                    m_valid  = 1;
                end
            end
        end else if (m_valid) begin
            if (a && s) begin
                m_valid = 0;
                m_alarm = 0;
                model_open();
            end else begin
                if (a) begin
                    m_valid = 0;
                    m_alarm = 0;
                end
                if (v) m_overrun = 1;
            end
        end else begin
            if (s) model_open();
            else if (v) m_overrun = 1;
        end
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".busy"},    8'(bus.out_busy),    8'(m_busy));
        chk({tag, ".valid"},   8'(bus.out_valid),   8'(m_valid));
        chk({tag, ".count"},   8'(bus.out_count),   8'(m_count));
        chk({tag, ".alarm"},   8'(bus.out_alarm),   8'(m_alarm));
        chk({tag, ".overrun"}, 8'(bus.out_overrun), 8'(m_overrun));
        chk({tag, ".max_run"}, 8'(bus.out_max_run), 8'(m_maxrun));
    endtask

    task automatic step(input bit s, input bit v, input bit d, input bit a, input string tag);
        bus.in_start = s;
        bus.in_valid = v;
        bus.in_sum   = d;
        bus.in_ack   = a;
        @(posedge clk);
        model_edge(s, v, d, a);
        #1;
        check_all(tag);
    endtask

    task automatic idle_inputs();
        bus.in_start = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_sum   = 1'b0;
        bus.in_ack   = 1'b0;
    endtask

    initial begin
        clk   = 1'b0;
        rst_n = 1'b0;
        idle_inputs();
        model_reset();
        #12;
        check_all("reset");
        rst_n = 1'b1;

        // Reset in the middle of a window, then a full window of ones.
        step(1'b1, 1'b0, 1'b0, 1'b0, "start_a");
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b1, 1'b0, "ones_pre_rst");
        #3;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all("async_rst");
        #1;
        rst_n = 1'b1;
        idle_inputs();
        step(1'b1, 1'b0, 1'b0, 1'b0, "start_b");
        for (int i = 0; i < WIN_LEN; i++) step(1'b0, 1'b1, 1'b1, 1'b0, "ones_win");
        chk("all_ones_count", 8'(bus.out_count), 8'd16);
        chk("all_ones_alarm", 8'(bus.out_alarm), 8'd1);
        step(1'b0, 1'b0, 1'b0, 1'b1, "ack_b");

        // Alternating pattern, back-to-back samples.
        step(1'b1, 1'b0, 1'b0, 1'b0, "start_c");
        for (int i = 0; i < WIN_LEN; i++) step(1'b0, 1'b1, ((i % 2) == 0), 1'b0, "alt_win");
        chk("alt_count", 8'(bus.out_count), 8'd8);
        chk("alt_alarm", 8'(bus.out_alarm), 8'd1);
        chk("alt_maxrun", 8'(bus.out_max_run), 8'(RUN_ON));
        step(1'b0, 1'b0, 1'b0, 1'b1, "ack_c");

        // 1,1,1,0 then zeros, with idle gaps between samples.
        step(1'b1, 1'b0, 1'b0, 1'b0, "start_d");
        for (int i = 0; i < WIN_LEN; i++) begin
            step(1'b0, 1'b1, (i < 3), 1'b0, "gap_win");
            if (i < WIN_LEN - 1) step(1'b0, 1'b0, 1'b1, 1'b0, "gap_idle");
        end
        chk("gap_count", 8'(bus.out_count), 8'd3);
        chk("gap_alarm", 8'(bus.out_alarm), 8'd0);
        chk("gap_maxrun", 8'(bus.out_max_run), 8'(3 * RUN_ON));

        // Overrun while holding; start without ack is ignored.
        step(1'b0, 1'b1, 1'b1, 1'b0, "hold_overrun");
        chk("hold_overrun_flag", 8'(bus.out_overrun), 8'd1);
        chk("hold_count_kept", 8'(bus.out_count), 8'd3);
        step(1'b1, 1'b0, 1'b0, 1'b0, "hold_start_ignored");
        step(1'b0, 1'b0, 1'b0, 1'b1, "ack_d");
        step(1'b1, 1'b0, 1'b0, 1'b0, "start_clears_overrun");
        chk("overrun_cleared", 8'(bus.out_overrun), 8'd0);

        // Random window, then ack+start back-to-back into an all-zero window.
        for (int i = 0; i < WIN_LEN; i++) step(1'b0, 1'b1, 1'($urandom_range(0, 1)), 1'b0, "rand_win");
        step(1'b1, 1'b0, 1'b0, 1'b1, "ack_start");
        chk("b2b_valid", 8'(bus.out_valid), 8'd0);
        chk("b2b_busy", 8'(bus.out_busy), 8'd1);
        for (int i = 0; i < WIN_LEN; i++) step(1'b0, 1'b1, 1'b0, 1'b0, "zero_win");
        chk("zero_count", 8'(bus.out_count), 8'd0);
        step(1'b0, 1'b0, 1'b0, 1'b1, "ack_e");

        // Restart after 7 samples: 16 further samples needed.
        step(1'b1, 1'b0, 1'b0, 1'b0, "start_f");
        for (int i = 0; i < 7; i++) step(1'b0, 1'b1, 1'b1, 1'b0, "pre_restart");
        step(1'b1, 1'b1, 1'b1, 1'b0, "restart");
        for (int i = 0; i < WIN_LEN - 1; i++) step(1'b0, 1'b1, (i < 2), 1'b0, "post_restart");
        chk("restart_not_done", 8'(bus.out_valid), 8'd0);
        step(1'b0, 1'b1, 1'b0, 1'b0, "restart_last");
        chk("restart_count", 8'(bus.out_count), 8'd2);
        step(1'b0, 1'b0, 1'b0, 1'b1, "ack_f");

        // Randomized traffic against the model.
        for (int i = 0; i < 800; i++) begin
            step(($urandom_range(0, 19) == 0),
                 ($urandom_range(0, 9) < 7),
                 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 3) == 0),
                 "random");
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
